// File: rtl/status_bar_renderer_pkg.sv
// rtl/status_bar_renderer_pkg.sv - shared encodings, colours and helpers for the status bar renderer
package status_bar_renderer_pkg;

    typedef enum logic [2:0] {
        S_MENU = 3'd0,
        S_GAME = 3'd1
    } game_state_e;

    // RRRGGGBB
    localparam logic [7:0] RED      = 8'b111_000_00;
    localparam logic [7:0] DARK_RED = 8'b100_000_00;
    localparam logic [7:0] WHITE    = 8'b111_111_11;
    localparam logic [7:0] BLUE     = 8'b000_000_11;
    localparam logic [7:0] BLACK    = 8'b000_000_00;

    typedef struct packed {
        logic       active;
        logic [7:0] color;
    } pix_t;

    function automatic logic phase_bit(input logic [7:0] cnt, input int sel);
        return cnt[sel];
    endfunction

endpackage

// File: rtl/status_bar_renderer_if.sv
// rtl/status_bar_renderer_if.sv - pixel position, frame status inputs and pixel output bundle
interface status_bar_renderer_if #(
    parameter int NUM_PIPS = 3
);
    logic                frame_tick;
    logic [2:0]          game_state;
    logic [9:0]          x;
    logic [9:0]          y;
    logic [NUM_PIPS-1:0] char1_health;
    logic [NUM_PIPS-1:0] char1_block;
    logic [NUM_PIPS-1:0] char2_health;
    logic [NUM_PIPS-1:0] char2_block;
    logic                active;
    logic [7:0]          pixel_color;

    modport master (
        output frame_tick, game_state, x, y,
        output char1_health, char1_block, char2_health, char2_block,
        input  active, pixel_color
    );

    modport slave (
        input  frame_tick, game_state, x, y,
        input  char1_health, char1_block, char2_health, char2_block,
        output active, pixel_color
    );
endinterface

// File: rtl/status_bar_renderer_flash.sv
// rtl/status_bar_renderer_flash.sv - pip_flash_tracker: per-player status latch with lost-heart flash window
module pip_flash_tracker #(
    parameter int NUM_PIPS     = 3,
    parameter int FLASH_FRAMES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                latch,
    input  logic                entry,
    input  logic [NUM_PIPS-1:0] health,
    input  logic [NUM_PIPS-1:0] block,
    output logic [NUM_PIPS-1:0] health_q,
    output logic [NUM_PIPS-1:0] block_q,
    output logic [NUM_PIPS-1:0] flash_mask
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    logic [CW-1:0]       flash_cnt;
    logic [NUM_PIPS-1:0] lost;
    logic [NUM_PIPS-1:0] regained;

    assign lost     = health_q & ~health;
    assign regained = ~health_q & health;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health_q   <= '0;
            block_q    <= '0;
            flash_mask <= '0;
            flash_cnt  <= '0;
        end else if (latch) begin
            health_q <= health;
            block_q  <= block;
            // Entering the game loads fresh status without treating it as damage
            if (entry) begin
                flash_mask <= '0;
                flash_cnt  <= '0;
            end else if (lost != '0) begin
                flash_mask <= (flash_mask | lost) & ~regained;
                flash_cnt  <= CW'(FLASH_FRAMES);
            end else if (flash_cnt != '0) begin
                flash_cnt  <= flash_cnt - 1'b1;
                flash_mask <= (flash_cnt == CW'(1)) ? '0 : (flash_mask & ~regained);
            end else begin
                flash_mask <= flash_mask & ~regained;
            end
        end
    end
endmodule

// File: rtl/status_bar_renderer.sv
// rtl/status_bar_renderer.sv - two-player heart/block bar overlay with frame-latched status and 2-stage pixel pipe
module status_bar_renderer
    import status_bar_renderer_pkg::*;
#(
    parameter int NUM_PIPS     = 3,
    parameter int PIP_W        = 40,
    parameter int PIP_H        = 40,
    parameter int PIP_PITCH    = 60,
    parameter int BAR_H        = 10,
    parameter int BAR_DY       = 50,
    parameter int P1_X0        = 100,
    parameter int P2_X0        = 380,
    parameter int Y0           = 410,
    parameter int FLASH_FRAMES = 16,
    parameter int BLINK_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    status_bar_renderer_if.slave  bus
);
    logic                  in_game;
    logic                  in_game_q;
    logic                  latch;
    logic [7:0]            frame_cnt;
    logic [NUM_PIPS-1:0]   h1_q, b1_q, f1, h2_q, b2_q, f2;

    assign in_game = (bus.game_state == S_GAME);
    assign latch   = bus.frame_tick && in_game;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_game_q <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (!in_game)
                in_game_q <= 1'b0;
            else if (bus.frame_tick)
                in_game_q <= 1'b1;
            if (latch)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    pip_flash_tracker #(.NUM_PIPS(NUM_PIPS), .FLASH_FRAMES(FLASH_FRAMES)) u_p1 (
        .clk(clk), .rst_n(rst_n), .latch(latch), .entry(!in_game_q),
        .health(bus.char1_health), .block(bus.char1_block),
        .health_q(h1_q), .block_q(b1_q), .flash_mask(f1)
    );

    pip_flash_tracker #(.NUM_PIPS(NUM_PIPS), .FLASH_FRAMES(FLASH_FRAMES)) u_p2 (
        .clk(clk), .rst_n(rst_n), .latch(latch), .entry(!in_game_q),
        .health(bus.char2_health), .block(bus.char2_block),
        .health_q(h2_q), .block_q(b2_q), .flash_mask(f2)
    );

    // Geometry: bit i is P1 pip i, bit NUM_PIPS+i is P2 pip i (P2 bit 0 rightmost)
    logic [10:0]           xw, yw;
    logic                  heart_row, bar_row;
    logic [2*NUM_PIPS-1:0] heart_hit, bar_hit;

    assign xw        = {1'b0, bus.x};
    assign yw        = {1'b0, bus.y};
    assign heart_row = (yw >= 11'(Y0)) && (yw < 11'(Y0 + PIP_H));
    assign bar_row   = (yw >= 11'(Y0 + BAR_DY)) && (yw < 11'(Y0 + BAR_DY + BAR_H));

    for (genvar i = 0; i < NUM_PIPS; i++) begin : g_pip
        localparam logic [10:0] L1 = 11'(P1_X0 + i * PIP_PITCH);
        localparam logic [10:0] L2 = 11'(P2_X0 + (NUM_PIPS - 1 - i) * PIP_PITCH);
        logic in1, in2;
        assign in1 = (xw >= L1) && (xw < L1 + 11'(PIP_W));
        assign in2 = (xw >= L2) && (xw < L2 + 11'(PIP_W));
        assign heart_hit[i]            = in1 && heart_row;
        assign bar_hit[i]              = in1 && bar_row;
        assign heart_hit[NUM_PIPS + i] = in2 && heart_row;
        assign bar_hit[NUM_PIPS + i]   = in2 && bar_row;
    end

    logic [2*NUM_PIPS-1:0] heart_hit_q, bar_hit_q;
    logic                  p2_sel_q;
    logic                  p1_any, p2_any;

    assign p1_any = |(heart_hit[NUM_PIPS-1:0] | bar_hit[NUM_PIPS-1:0]);
    assign p2_any = |(heart_hit[2*NUM_PIPS-1:NUM_PIPS] | bar_hit[2*NUM_PIPS-1:NUM_PIPS]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heart_hit_q <= '0;
            bar_hit_q   <= '0;
            p2_sel_q    <= 1'b0;
        end else begin
            heart_hit_q <= in_game ? heart_hit : '0;
            bar_hit_q   <= in_game ? bar_hit : '0;
            p2_sel_q    <= in_game && !p1_any && p2_any;
        end
    end

    logic [NUM_PIPS-1:0] hh, bh, h_sel, b_sel, f_sel;
    logic                last, blink;
    pix_t                pix_d, pix_q;

    always_comb begin
        hh    = p2_sel_q ? heart_hit_q[2*NUM_PIPS-1:NUM_PIPS] : heart_hit_q[NUM_PIPS-1:0];
        bh    = p2_sel_q ? bar_hit_q[2*NUM_PIPS-1:NUM_PIPS]   : bar_hit_q[NUM_PIPS-1:0];
        h_sel = p2_sel_q ? h2_q : h1_q;
        b_sel = p2_sel_q ? b2_q : b1_q;
        f_sel = p2_sel_q ? f2   : f1;
        last  = (h_sel != '0) && ((h_sel & (h_sel - 1'b1)) == '0);
        blink = phase_bit(frame_cnt, BLINK_LOG2);
        pix_d = '0;
        // Descending scan so the lowest hit index has the final say
        for (int i = NUM_PIPS - 1; i >= 0; i--) begin
            if (hh[i]) begin
                pix_d.active = 1'b1;
                if (f_sel[i])
                    pix_d.color = blink ? WHITE : RED;
                else if (!h_sel[i])
                    pix_d.color = BLACK;
                else if (last)
                    pix_d.color = blink ? RED : DARK_RED;
                else
                    pix_d.color = RED;
            end else if (bh[i]) begin
                pix_d.active = 1'b1;
                pix_d.color  = b_sel[i] ? BLUE : WHITE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_q <= '0;
        else
            pix_q <= pix_d;
    end

    assign bus.active      = pix_q.active;
    assign bus.pixel_color = pix_q.color;
endmodule

// File: doc/status_bar_renderer.md
Name: status_bar_renderer

Overview:
- Parametrised successor of the in-game heart/block bar drawing.
- Draws NUM_PIPS health pips and NUM_PIPS block bars for two players.
- Latches status once per frame on frame_tick so the bars never tear mid-frame.
- Animates lost hearts with a timed flash, pulses a last remaining heart, and feeds a 2-stage pixel pipeline into vga_handler compositing.

Parameters:
- NUM_PIPS, 3, pips per player; width of every status mask.
- PIP_W, 40, pip width (px).
- PIP_H, 40, heart height (px).
- PIP_PITCH, 60, x distance between pip left edges.
- BAR_H, 10, block bar height (px).
- BAR_DY, 50, offset from heart top to bar top.
- P1_X0, 100, left edge of player-1 pip 0.
- P2_X0, 380, left edge of player-2 leftmost pip.
- Y0, 410, heart top y.
- FLASH_FRAMES, 16, frames a lost heart flashes.
- BLINK_LOG2, 2, flash/pulse phase toggles every 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at vertical-blank start
- game_state  in  3  controller state; S_GAME=3'd1
- x  in  10  VGA x
- y  in  10  VGA y
- char1_health  in  NUM_PIPS  player-1 heart mask, bit i = pip i present
- char1_block  in  NUM_PIPS  player-1 block mask
- char2_health  in  NUM_PIPS  player-2 heart mask
- char2_block  in  NUM_PIPS  player-2 block mask
- active  out  1  pixel lies in any pip/bar
- pixel_color  out  8  RRRGGGBB

Behaviour:
- Reset values:
  - active=0, pixel_color=0.
  - Latched masks = 0, flash masks = 0.
  - Flash counters = 0, frame counter = 0, in_game_q = 0.
- Geometry:
  - P1 pip i is at x∈[P1_X0+i·PIP_PITCH, +PIP_W).
  - P2 pip i is at x∈[P2_X0+(NUM_PIPS-1-i)·PIP_PITCH, +PIP_W), so P2 bit 0 is rightmost.
  - Heart y∈[Y0, Y0+PIP_H). Bar y∈[Y0+BAR_DY, +BAR_H).
  - All bounds are half-open and use constant comparisons only; no multipliers or dividers on x/y.
- Latch: on frame_tick && game_state==S_GAME:
  - h1_q, b1_q, h2_q, b2_q ← inputs.
  - frame counter +1, wrapping mod 2^8.
  - Inputs are ignored between ticks.
- Game entry: on the first such tick after in_game_q=0, masks load with no flash and in_game_q←1. When game_state≠S_GAME, in_game_q←0.
- Flash, per player p, on each latching tick with in_game_q=1:
  - lost = h_q & ~h_new.
  - If lost≠0: flash_mask_p ← flash_mask_p | lost and flash_cnt_p ← FLASH_FRAMES. This restarts the window; new damage during a flash accumulates.
  - Else if flash_cnt_p≠0: decrement; on reaching 0, clear flash_mask_p.
  - Health regain clears the regained bits from flash_mask_p.
- Phase: blink_on = frame_cnt[BLINK_LOG2].
- Pipeline, latency exactly 2 clocks from x,y to outputs:
  - Stage 1 registers the per-pip heart and bar hit vectors (2·NUM_PIPS each) and the player select.
  - Stage 2 registers active and pixel_color.
- Colour priority:
  - Heart hit, flash bit set: blink_on ? 111_111_11 : 111_000_00.
  - Heart hit, present, only pip present for that player: blink_on ? 111_000_00 : 100_000_00.
  - Heart hit, present otherwise: 111_000_00. Absent: 000_000_00.
  - Bar hit: present 000_000_11; absent 111_111_11.
  - No hit: active=0, pixel_color=0.
- game_state≠S_GAME: active=0, pixel_color=0 from stage 2 onward; latched state is held.
- Overlap: overlapping pips are a parameter error; hit vectors are one-hot, and the lowest index wins if violated.
- Reset mid-frame: outputs go to 0 immediately. The first post-reset tick in game is treated as game entry.

Decomposition:
- Shared package holds:
  - S_MENU/S_GAME encodings.
  - Colour constants: RED, DARK_RED, WHITE, BLUE, BLACK.
- One sub-module, pip_flash_tracker: per-player latch, lost-detect, flash mask and counter. It is instantiated twice.
- Geometry compare and colour pipeline stay in the top.

Test Plan:
1. Reset, game_state=1, tick with h1=3'b111, b1=3'b101. Pixel (110,420) → red after 2 clk; (230,465) → blue; (170,465) → white.
2. h1 drops 111→011 between ticks. Pixel (230,420) keeps the old colour until the tick. After the tick, the pip flashes white/red toggling every 4 frames for 16 frames, then stays black.
3. Second hit during a flash (011→001 at frame 5): flash_mask=3'b110, counter reloads to 16, both pips flash.
4. h2=3'b001 steady. Pixel (530,420), P2 bit 0 rightmost, alternates 111_000_00 / 100_000_00 every 4 frames; (390,420) → black.
5. game_state=0 → active=0 everywhere. Returning to 1 with an h1 change produces no flash on entry.
6. rst_n low mid-line at (120,420) → active/pixel_color 0 asynchronously. Release, no tick yet → pip pixels show black/white from zeroed masks.
